// File: rtl/ysyx_22050854_axi_rd_slave_pkg.sv
// rtl/ysyx_22050854_axi_rd_slave_pkg.sv - shared AXI burst/response encodings
//
// Purpose: AXI4 burst-type and response-code encodings shared by the AXI
//          slaves, plus a helper that turns an AxSIZE field into a byte step.
// Ports:   none (package).
package ysyx_22050854_axi_rd_slave_pkg;

  typedef logic [1:0] axi_burst_t;
  typedef logic [1:0] axi_resp_t;

  localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
  localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
  localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

  // Bytes per beat for a given AxSIZE encoding.
  function automatic logic [31:0] axi_size_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/ysyx_22050854_axi_rd_slave_reg.sv
// rtl/ysyx_22050854_axi_rd_slave_reg.sv - generic enable register
//
// Purpose: WIDTH-bit register with synchronous active-high reset to RESET_VAL
//          and a write enable.
// Ports:   clock, reset - clock and synchronous active-high reset
//          din, wen     - data in and load enable
//          dout         - registered data
module ysyx_22050854_Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  always_ff @(posedge clock) begin
    if (reset) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_22050854_axi_rd_slave.sv
// rtl/ysyx_22050854_axi_rd_slave.sv - AXI4 read slave in front of a 1-cycle SRAM
//
// Purpose: accepts one AR burst at a time, waits LATENCY cycles, then returns
//          arlen+1 beats read from a backing SRAM whose data is valid the cycle
//          after mem_ren. Unsupported bursts (WRAP/reserved, oversize beats)
//          return SLVERR beats without touching the SRAM.
// Ports:   clock, reset                          - clock, sync active-high reset
//          arvalid/arready/arid/araddr/arlen/
//          arsize/arburst                        - AXI4 read-address channel
//          rvalid/rready/rid/rdata/rresp/rlast   - AXI4 read-data channel
//          mem_ren/mem_raddr/mem_rdata           - backing SRAM read port
import ysyx_22050854_axi_rd_slave_pkg::*;

module ysyx_22050854_axi_rd_slave #(
  parameter int ID_W    = 4,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  output logic              rvalid,
  input  logic              rready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              mem_ren,
  output logic [31:0]       mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int         CNT_W    = 4;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));
  localparam int         CAP_W    = ID_W + 8 + 3 + 2 + 1;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_wait;
  logic [7:0]       r_beat;
  logic [31:0]      r_addr;

  logic             w_ar_hs;
  logic             w_r_hs;
  logic             w_ar_err;
  logic             w_last;
  logic [31:0]      w_next_addr;

  logic [ID_W-1:0]  w_id;
  logic [7:0]       w_len;
  logic [2:0]       w_size;
  logic [1:0]       w_burst;
  logic             w_err;

  // Error bursts are classified once at AR time and carried with the fields.
  assign w_ar_err = (arburst == AXI_BURST_WRAP) || (arburst == 2'b11) || (arsize > MAX_SIZE);

  ysyx_22050854_Reg #(
    .WIDTH     (CAP_W),
    .RESET_VAL ('0)
  ) u_ar_cap (
    .clock (clock),
    .reset (reset),
    .din   ({arid, arlen, arsize, arburst, w_ar_err}),
    .dout  ({w_id, w_len, w_size, w_burst, w_err}),
    .wen   (w_ar_hs)
  );

  // Outputs are gated by reset so they read idle in the reset cycle itself.
  assign arready = !reset && (r_state == S_IDLE);
  assign rvalid  = !reset && (r_state == S_RESP);
  assign mem_ren = !reset && (r_state == S_FETCH);

  assign w_ar_hs = arvalid && arready;
  assign w_r_hs  = rvalid && rready;
  assign w_last  = (r_beat == w_len);

  assign mem_raddr = reset ? 32'd0 : r_addr;
  assign rid       = reset ? '0 : w_id;
  assign rlast     = rvalid && w_last;
  assign rresp     = (rvalid && w_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  // SRAM data is held until the next mem_ren, and no fetch happens while
  // stalled in RESP, so rdata stays stable for the whole beat.
  assign rdata     = (rvalid && !w_err) ? mem_rdata : '0;

  assign w_next_addr = (w_burst == AXI_BURST_INCR) ? (r_addr + axi_size_bytes(w_size)) : r_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_beat  <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ar_hs) begin
            r_addr <= araddr;
            r_beat <= '0;
            r_wait <= CNT_W'(LATENCY);
            if (LATENCY > 0) begin
              r_state <= S_WAIT;
            end else if (w_ar_err) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_WAIT: begin
          r_wait <= r_wait - CNT_W'(1);
          if (r_wait == CNT_W'(1)) begin
            r_state <= w_err ? S_RESP : S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_r_hs) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_beat  <= r_beat + 8'd1;
              r_addr  <= w_next_addr;
              // Error beats need no SRAM access, so stay in RESP.
              r_state <= w_err ? S_RESP : S_FETCH;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_axi_rd_slave.sv
// tb/tb_ysyx_22050854_axi_rd_slave.sv - directed bench for the AXI read slave
module tb_ysyx_22050854_axi_rd_slave;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
    logic [31:0] cyc;
  } beat_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] cyc;
  } ren_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic [63:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  beat_t beats[$];
  ren_t  rens[$];

  logic        sram_req = 1'b0;
  logic [31:0] sram_addr = '0;

  ysyx_22050854_axi_rd_slave #(
    .ID_W    (4),
    .DATA_W  (64),
    .LATENCY (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .arvalid   (arvalid),
    .arready   (arready),
    .arid      (arid),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .rvalid    (rvalid),
    .rready    (rready),
    .rid       (rid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, a};
  endfunction

  function automatic beat_t gb(input int i);
    if (i < beats.size()) return beats[i];
    return 'x;
  endfunction

  function automatic ren_t gr(input int i);
    if (i < rens.size()) return rens[i];
    return 'x;
  endfunction

  // Monitor: logs SRAM reads and R handshakes, sampled on the falling edge.
  always @(negedge clock) begin
    sram_req = (mem_ren === 1'b1);
    sram_addr = mem_raddr;
    if (mem_ren === 1'b1) rens.push_back('{addr: mem_raddr, cyc: 32'(cyc)});
    if (rvalid === 1'b1 && rready === 1'b1)
      beats.push_back('{data: rdata, id: rid, resp: rresp, last: rlast, cyc: 32'(cyc)});
  end

  // SRAM model: data appears the cycle after mem_ren and holds until the next read.
  always @(posedge clock) begin
    if (sram_req) begin
      #1;
      mem_rdata = pat(sram_addr);
    end
  end

  task automatic clear_logs();
    beats.delete();
    rens.delete();
  endtask

  task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, output int t_hs);
    bit got;
    got = 0;
    t_hs = -1;
    arvalid = 1'b1;
    arid = id;
    araddr = addr;
    arlen = len;
    arsize = size;
    arburst = burst;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      if (arready === 1'b1) begin
        got = 1;
        t_hs = cyc;
      end
    end
    @(posedge clock);
    #1;
    arvalid = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL ar_handshake: arready never seen, required 1");
    end
  endtask

  task automatic wait_beats(input int n, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clock);
      #1;
      if (beats.size() >= n) done = 1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL beat_timeout: got %0d beats, required %0d", beats.size(), n);
    end
  endtask

  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output int t_hs);
    clear_logs();
    rready = 1'b1;
    issue_ar(id, addr, len, size, burst, t_hs);
    wait_beats(int'(len) + 1, 2000);
  endtask

  task automatic check_idle_after(input string name);
    @(negedge clock);
    vectors++;
    if (arready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_arready_after: got %b, required 1", name, arready);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    arvalid = 1'b0;
    arid = '0;
    araddr = '0;
    arlen = '0;
    arsize = '0;
    arburst = '0;
    rready = 1'b1;
    mem_rdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({arready, rvalid, rlast, rresp, rid, mem_ren, mem_raddr} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: arready=%b rvalid=%b rlast=%b rresp=%b rid=%h mem_ren=%b mem_raddr=%h, required all 0",
               arready, rvalid, rlast, rresp, rid, mem_ren, mem_raddr);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (arready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_arready: got %b, required 1", arready);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_single();
    int t;
    beat_t b;
    ren_t r;
    run_burst(4'd1, 32'h8000_0000, 8'd0, 3'd3, 2'b01, t);
    r = gr(0);
    b = gb(0);
    vectors++;
    if (rens.size() !== 1 || r.addr !== 32'h8000_0000 || r.cyc !== 32'(t + 3)) begin
      miscompares++;
      $display("FAIL single_fetch: count=%0d addr=%h cyc=%0d, required 1/80000000/%0d", rens.size(), r.addr, r.cyc, t + 3);
    end
    vectors++;
    if (b.cyc !== 32'(t + 4) || b.last !== 1'b1 || b.id !== 4'd1 || b.resp !== 2'b00) begin
      miscompares++;
      $display("FAIL single_beat: cyc=%0d last=%b id=%h resp=%b, required %0d/1/1/00", b.cyc, b.last, b.id, b.resp, t + 4);
    end
    vectors++;
    if (b.data !== pat(32'h8000_0000)) begin
      miscompares++;
      $display("FAIL single_data: got %h, required %h", b.data, pat(32'h8000_0000));
    end
    check_idle_after("single");
  endtask

  task automatic test_incr();
    int t;
    beat_t b;
    ren_t r;
    logic [31:0] a;
    run_burst(4'd2, 32'h8000_0010, 8'd3, 3'd3, 2'b01, t);
    vectors++;
    if (beats.size() !== 4 || rens.size() !== 4) begin
      miscompares++;
      $display("FAIL incr_count: beats=%0d fetches=%0d, required 4/4", beats.size(), rens.size());
    end
    for (int k = 0; k < 4; k++) begin
      a = 32'h8000_0010 + 32'(k * 8);
      r = gr(k);
      b = gb(k);
      vectors++;
      if (r.addr !== a || b.data !== pat(a) || b.last !== (k == 3) || b.cyc !== 32'(t + 4 + 2 * k) || b.id !== 4'd2) begin
        miscompares++;
        $display("FAIL incr_beat%0d: addr=%h data=%h last=%b cyc=%0d id=%h, required %h/%h/%b/%0d/2",
                 k, r.addr, b.data, b.last, b.cyc, b.id, a, pat(a), (k == 3), t + 4 + 2 * k);
      end
    end
    check_idle_after("incr");
  endtask

  task automatic test_fixed();
    int t;
    ren_t r;
    run_burst(4'd6, 32'h8000_0100, 8'd2, 3'd2, 2'b00, t);
    vectors++;
    if (rens.size() !== 3 || beats.size() !== 3) begin
      miscompares++;
      $display("FAIL fixed_count: fetches=%0d beats=%0d, required 3/3", rens.size(), beats.size());
    end
    for (int k = 0; k < 3; k++) begin
      r = gr(k);
      vectors++;
      if (r.addr !== 32'h8000_0100) begin
        miscompares++;
        $display("FAIL fixed_addr%0d: got %h, required 80000100", k, r.addr);
      end
    end
  endtask

  task automatic test_stall();
    int t;
    int h;
    bit seen;
    beat_t b;
    ren_t r;
    clear_logs();
    rready = 1'b0;
    issue_ar(4'd3, 32'h8000_0040, 8'd1, 3'd3, 2'b01, t);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (rvalid === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen || cyc !== t + 4) begin
      miscompares++;
      $display("FAIL stall_first_valid: seen=%0d cyc=%0d, required 1/%0d", seen, cyc, t + 4);
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (rvalid !== 1'b1 || rdata !== pat(32'h8000_0040) || mem_ren !== 1'b0 || rlast !== 1'b0 ||
          arready !== 1'b0 || rid !== 4'd3) begin
        miscompares++;
        $display("FAIL stall_hold%0d: rvalid=%b rdata=%h mem_ren=%b rlast=%b arready=%b rid=%h, required 1/%h/0/0/0/3",
                 k, rvalid, rdata, mem_ren, rlast, arready, rid, pat(32'h8000_0040));
      end
      if (k < 4) @(negedge clock);
    end
    @(posedge clock);
    #1;
    rready = 1'b1;
    @(negedge clock);
    h = cyc;
    vectors++;
    if (rens.size() !== 1) begin
      miscompares++;
      $display("FAIL stall_no_prefetch: fetches=%0d, required 1", rens.size());
    end
    wait_beats(2, 50);
    r = gr(1);
    b = gb(1);
    vectors++;
    if (r.addr !== 32'h8000_0048 || r.cyc !== 32'(h + 1) || b.data !== pat(32'h8000_0048) ||
        b.last !== 1'b1 || b.cyc !== 32'(h + 2)) begin
      miscompares++;
      $display("FAIL stall_next_beat: addr=%h fcyc=%0d data=%h last=%b bcyc=%0d, required 80000048/%0d/%h/1/%0d",
               r.addr, r.cyc, b.data, b.last, b.cyc, h + 1, pat(32'h8000_0048), h + 2);
    end
    b = gb(0);
    vectors++;
    if (b.last !== 1'b0 || b.cyc !== 32'(h)) begin
      miscompares++;
      $display("FAIL stall_beat0: last=%b cyc=%0d, required 0/%0d", b.last, b.cyc, h);
    end
  endtask

  task automatic test_error();
    int t;
    beat_t b;
    run_burst(4'd5, 32'h8000_0000, 8'd1, 3'd3, 2'b10, t);
    vectors++;
    if (rens.size() !== 0 || beats.size() !== 2) begin
      miscompares++;
      $display("FAIL err_wrap_count: fetches=%0d beats=%0d, required 0/2", rens.size(), beats.size());
    end
    for (int k = 0; k < 2; k++) begin
      b = gb(k);
      vectors++;
      if (b.resp !== 2'b10 || b.data !== 64'd0 || b.last !== (k == 1) || b.id !== 4'd5 || b.cyc !== 32'(t + 3 + k)) begin
        miscompares++;
        $display("FAIL err_wrap_beat%0d: resp=%b data=%h last=%b id=%h cyc=%0d, required 10/0/%b/5/%0d",
                 k, b.resp, b.data, b.last, b.id, b.cyc, (k == 1), t + 3 + k);
      end
    end
    run_burst(4'd7, 32'h8000_0000, 8'd0, 3'd4, 2'b01, t);
    b = gb(0);
    vectors++;
    if (rens.size() !== 0 || beats.size() !== 1 || b.resp !== 2'b10 || b.data !== 64'd0 || b.last !== 1'b1) begin
      miscompares++;
      $display("FAIL err_size: fetches=%0d beats=%0d resp=%b data=%h last=%b, required 0/1/10/0/1",
               rens.size(), beats.size(), b.resp, b.data, b.last);
    end
    check_idle_after("error");
  endtask

  task automatic test_reset_mid();
    int t;
    bit hit;
    ren_t r;
    beat_t b;
    clear_logs();
    rready = 1'b1;
    issue_ar(4'd4, 32'h8000_1000, 8'd7, 3'd3, 2'b01, t);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clock);
      #1;
      if (beats.size() == 2) hit = 1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL midrst_reach_beat2: beats=%0d, required 2", beats.size());
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #1;
    @(negedge clock);
    vectors++;
    if (rvalid !== 1'b0 || arready !== 1'b0 || mem_ren !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_during: rvalid=%b arready=%b mem_ren=%b, required 0/0/0", rvalid, arready, mem_ren);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (arready !== 1'b1 || rvalid !== 1'b0 || beats.size() !== 2) begin
      miscompares++;
      $display("FAIL midrst_after: arready=%b rvalid=%b beats=%0d, required 1/0/2", arready, rvalid, beats.size());
    end
    @(posedge clock);
    #1;
    run_burst(4'd9, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, t);
    r = gr(1);
    b = gb(1);
    vectors++;
    if (rens.size() !== 2 || r.addr !== 32'h0000_0000 || b.data !== pat(32'h0) || b.last !== 1'b1 || b.id !== 4'd9) begin
      miscompares++;
      $display("FAIL wrap32: fetches=%0d addr=%h data=%h last=%b id=%h, required 2/00000000/%h/1/9",
               rens.size(), r.addr, b.data, b.last, b.id, pat(32'h0));
    end
  endtask

  task automatic test_len255();
    int t;
    int nlast;
    beat_t b;
    ren_t r;
    run_burst(4'd15, 32'h8000_2000, 8'd255, 3'd3, 2'b01, t);
    nlast = 0;
    foreach (beats[i]) if (beats[i].last === 1'b1) nlast++;
    b = gb(255);
    r = gr(255);
    vectors++;
    if (beats.size() !== 256 || nlast !== 1 || b.last !== 1'b1) begin
      miscompares++;
      $display("FAIL len255_beats: beats=%0d lasts=%0d last255=%b, required 256/1/1", beats.size(), nlast, b.last);
    end
    vectors++;
    if (r.addr !== 32'h8000_27F8 || b.data !== pat(32'h8000_27F8)) begin
      miscompares++;
      $display("FAIL len255_final: addr=%h data=%h, required 800027f8/%h", r.addr, b.data, pat(32'h8000_27F8));
    end
    r = gr(128);
    vectors++;
    if (r.addr !== 32'h8000_2400) begin
      miscompares++;
      $display("FAIL len255_mid: addr=%h, required 80002400", r.addr);
    end
    check_idle_after("len255");
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr();
    test_fixed();
    test_stall();
    test_error();
    test_reset_mid();
    test_len255();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_22050854_axi_rd_slave.md
YSYX_22050854_AXI_RD_SLAVE -- requirements
Module: ysyx_22050854_AXI_rd_slave

Interface
REQ-001 SHALL have parameters: ID_W, default 4, AXI ID width; DATA_W, default 64, R data width; LATENCY, default 2, first-beat wait cycles (range 0..15).
REQ-002 SHALL have ports: clock  in  1  sole clock; reset is synchronous and active-high.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: arvalid in 1; arready out 1; arid in ID_W; araddr in 32; arlen in 8; arsize in 3; arburst in 2; these form the AXI4 read-address channel driven by the IFU/LSU arbiter.
REQ-005 SHALL have ports: rvalid out 1; rready in 1; rid out ID_W; rdata out DATA_W; rresp out 2; rlast out 1; these form the AXI4 read-data channel.
REQ-006 SHALL have ports: mem_ren out 1; mem_raddr out 32; mem_rdata in DATA_W; these form the backing-SRAM port, where mem_rdata is valid the cycle after mem_ren and is held until the next mem_ren.

Function
REQ-007 SHALL implement the following states: IDLE, WAIT, FETCH, RESP.
REQ-008 SHALL drive arready=1 only in IDLE, so that an AR handshake occurs on arvalid&arready.
REQ-009 SHALL, on handshake, capture arid, araddr, arlen, arsize and arburst, and clear the beat counter.
REQ-010 SHALL, on handshake, go to WAIT with count=LATENCY when LATENCY>0; otherwise it SHALL go to FETCH.
REQ-011 SHALL, in WAIT, decrement the count each cycle and leave WAIT in the cycle after the count reaches 1.
REQ-012 SHALL assert mem_ren=1 in FETCH for exactly one cycle, with mem_raddr equal to the current beat address, and then go to RESP.
REQ-013 SHALL assert rvalid=1 in RESP only, with rdata=mem_rdata, rid=captured arid, rresp=2'b00 (OKAY), and rlast=(beat_cnt==arlen).
REQ-014 SHALL give the first beat a latency of LATENCY+2 cycles: rvalid SHALL rise in cycle T+LATENCY+2 for an AR handshake in cycle T.
REQ-015 SHALL, on an R handshake with rlast=0, increment beat_cnt, update the address, and go to FETCH; subsequent beats SHALL therefore deliver at most one beat every 2 cycles.
REQ-016 SHALL, on an R handshake with rlast=1, go to IDLE, with arready=1 in the next cycle.
REQ-017 SHALL hold rvalid, rdata, rid, rresp and rlast stable while rvalid=1 and rready=0; mem_ren SHALL stay 0 during such a stall.
REQ-018 SHALL, for arburst=2'b01 (INCR), add (1<<arsize) to the address per beat, with a modulo 2^32 wrap.
REQ-019 SHALL, for arburst=2'b00 (FIXED), keep the address constant.
REQ-020 SHALL treat arburst=2'b10/2'b11, or arsize>log2(DATA_W/8), as an error burst: all arlen+1 beats SHALL be returned with rresp=2'b10 (SLVERR), rdata=0 and mem_ren=0, and the state machine SHALL go WAIT/IDLE->RESP, skipping FETCH.
REQ-021 SHALL support arlen=0 (single beat, rlast=1 on the first beat) and arlen=255 (256 beats) with an 8-bit beat counter.
REQ-022 SHALL ignore arvalid outside IDLE; one outstanding burst is allowed at a time.

Reset
REQ-023 SHALL, while reset=1, put the module in state IDLE and drive arready=0, rvalid=0, rlast=0, rresp=0, rid=0, mem_ren=0, mem_raddr=0, and clear the counters.
REQ-024 SHALL drive arready=1 in the first cycle after reset deasserts.
REQ-025 SHALL, on reset in mid-burst, drop the burst with no further beats, and rvalid SHALL be 0 from the next cycle.

Structure
REQ-026 SHALL take the AXI burst encodings (FIXED/INCR/WRAP) and response encodings (OKAY/SLVERR) from the shared AXI definitions package/header.
REQ-027 SHALL keep the state encodings and LATENCY counter width local to the module.
REQ-028 SHALL capture the AR fields with the existing ysyx_22050854_Reg register sub-module, enabled on the AR handshake.

Verification
REQ-029 SHALL be verified with: LATENCY=2, araddr=0x8000_0000, arlen=0, arsize=3, INCR, arid=1, rready=1 -> mem_ren in cycle T+3 with addr 0x8000_0000, rvalid/rlast=1 in cycle T+4, rid=1, rresp=0.
REQ-030 SHALL be verified with: araddr=0x8000_0010, arlen=3, arsize=3, INCR -> mem_raddr sequence 0x10, 0x18, 0x20, 0x28 (+0x8000_0000), rlast only on the 4th beat, arready=1 afterwards.
REQ-031 SHALL be verified with: FIXED burst, arlen=2 -> all three mem_raddr equal araddr.
REQ-032 SHALL be verified with: rready held 0 for 5 cycles on beat 0 -> rvalid and rdata unchanged and mem_ren=0 throughout, and the next beat is fetched only after the handshake.
REQ-033 SHALL be verified with: arburst=2'b10, arlen=1 -> 2 beats with rresp=2'b10, rdata=0 and mem_ren never asserted.
REQ-034 SHALL be verified with: reset asserted during beat 2 of arlen=7 -> rvalid=0 next cycle, arready=1 after reset deasserts, and a new burst completes normally; INCR with araddr=0xFFFF_FFF8, arlen=1 -> 2nd address 0x0000_0000.
